// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle shifter that moves one bit per clock. An accepted start captures
// the operand, the shift amount and the operation. The block then steps the
// working register once per cycle until the shift amount is used up, and
// pulses done for a single cycle.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : request pulse, only looked at while idle
//   data_in  : operand, captured on an accepted start
//   shamt    : shift amount, captured on an accepted start
//   op       : 00 SLL, 01 SRL, 10 SRA, 11 ROR, captured on an accepted start
//   result   : working register (registered)
//   cout     : last bit shifted or rotated out (registered)
//   busy     : high while shifting
//   done     : one-cycle pulse when result/cout hold the final value
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [1:0]               op,
    output logic [WIDTH-1:0]         result,
    output logic                     cout,
    output logic                     busy,
    output logic                     done
);

    localparam int            SW       = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_ZERO = '0;
    localparam logic [SW-1:0] CNT_ONE  = SW'(1);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              arm_q, arm_d;
    logic              accept;

    // arm_q stays low for the first edge after reset is released, so a start
    // that happens to be high on the edge coincident with release is ignored.
    assign accept = (state_q == IDLE) && start && arm_q;

    // State register and all output/datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SLL;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            arm_q   <= arm_d;
        end
    end

    // Next-state logic. The counter is at least one whenever SHIFT is entered,
    // so leaving on a count of one means the last step happens on this edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (shamt != CNT_ZERO) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic. busy/done are registered copies of the next
    // state, so they line up with the state register and never overlap.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        cout_d = cout_q;
        arm_d  = 1'b1;
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);

        if (accept) begin
            work_d = data_in;
            cnt_d  = shamt;
            op_d   = op;
            cout_d = 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_d = cnt_q - CNT_ONE;
            case (op_q)
                OP_SLL: begin
                    cout_d = work_q[WIDTH-1];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                OP_SRL: begin
                    cout_d = work_q[0];
                    work_d = {1'b0, work_q[WIDTH-1:1]};
                end
                OP_SRA: begin
                    cout_d = work_q[0];
                    work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                end
                OP_ROR: begin
                    cout_d = work_q[0];
                    work_d = {work_q[0], work_q[WIDTH-1:1]};
                end
                default: begin
                    cout_d = cout_q;
                    work_d = work_q;
                end
            endcase
        end
    end

    assign result = work_q;
    assign cout   = cout_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
//
// Directed checks of seq_shifter followed by a full sweep of every operand,
// shift amount and operation. Expected results come from a shift-operator
// model and travel through a scoreboard queue from stimulus to checking.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [2:0]   shamt;
    logic [1:0]   op;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        int           n;
    } exp_t;

    exp_t         exp_q[$];
    int           errors;
    int           checks;
    int           num_correct;
    int           num_wrong;
    logic [W-1:0] last_res;
    logic         last_cout;

    seq_shifter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .op      (op),
        .result  (result),
        .cout    (cout),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-word reference built from shift operators rather than bit steps.
    function automatic exp_t model(input logic [W-1:0] d, input int n, input logic [1:0] o);
        exp_t e;
        e.n = n;
        if (n == 0) begin
            e.res  = d;
            e.cout = 1'b0;
        end else begin
            case (o)
                2'b00: begin e.res = d << n;                    e.cout = d[W-n]; end
                2'b01: begin e.res = d >> n;                    e.cout = d[n-1]; end
                2'b10: begin e.res = W'($signed(d) >>> n);      e.cout = d[n-1]; end
                default: begin e.res = (d >> n) | (d << (W-n)); e.cout = d[n-1]; end
            endcase
        end
        return e;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one request on a falling edge and queues its expected outcome;
    // the request is accepted on the following rising edge.
    task automatic applyStimulus(input logic [W-1:0] d, input int n, input logic [1:0] o, input bit hold);
        @(negedge clk);
        data_in = d;
        shamt   = 3'(n);
        op      = o;
        start   = 1'b1;
        exp_q.push_back(model(d, n, o));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    // Follows one operation cycle by cycle: busy for N cycles, then done,
    // then result/cout against the scoreboard entry. With disturb set, start
    // is pulsed with fresh operands during the first two shifting cycles.
    task automatic checkOutput(input bit disturb);
        exp_t e;
        e = exp_q.pop_front();
        for (int c = 1; c <= e.n + 1; c++) begin
            @(negedge clk);
            checkValue($sformatf("busy_n%0d_c%0d", e.n, c), 32'(busy), 32'(c <= e.n));
            checkValue($sformatf("done_n%0d_c%0d", e.n, c), 32'(done), 32'(c == e.n + 1));
            if (disturb && c <= 2) begin
                start   = 1'b1;
                data_in = ~data_in;
                shamt   = 3'd1;
                op      = ~op;
            end else if (disturb && c == 3) begin
                start = 1'b0;
            end
        end
        checkValue("result", 32'(result), 32'(e.res));
        checkValue("cout", 32'(cout), 32'(e.cout));
        last_res  = result;
        last_cout = cout;
    endtask

    initial begin
        int err_before;

        errors      = 0;
        checks      = 0;
        num_correct = 0;
        num_wrong   = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        data_in     = '0;
        shamt       = '0;
        op          = 2'b00;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkValue("rst_result", 32'(result), 32'h0);
        checkValue("rst_cout", 32'(cout), 32'h0);
        checkValue("rst_busy", 32'(busy), 32'h0);
        checkValue("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reference vectors.
        applyStimulus(8'b1011_0001, 3, 2'b00, 1'b0);
        checkOutput(1'b0);
        checkValue("sll_vec_result", 32'(last_res), 32'(8'b1000_1000));
        checkValue("sll_vec_cout", 32'(last_cout), 32'h1);

        applyStimulus(8'b1001_0110, 2, 2'b10, 1'b0);
        checkOutput(1'b0);
        checkValue("sra_vec_result", 32'(last_res), 32'(8'b1110_0101));
        checkValue("sra_vec_cout", 32'(last_cout), 32'h1);

        applyStimulus(8'b1001_0110, 2, 2'b01, 1'b0);
        checkOutput(1'b0);
        checkValue("srl_vec_result", 32'(last_res), 32'(8'b0010_0101));
        checkValue("srl_vec_cout", 32'(last_cout), 32'h1);

        applyStimulus(8'h81, 7, 2'b11, 1'b0);
        checkOutput(1'b0);
        checkValue("ror_vec_result", 32'(last_res), 32'h03);
        checkValue("ror_vec_cout", 32'(last_cout), 32'h0);

        // Zero shift amount for every operation.
        for (int o = 0; o < 4; o++) begin
            applyStimulus(8'h5A, 0, 2'(o), 1'b0);
            checkOutput(1'b0);
            checkValue("zero_shift_result", 32'(last_res), 32'h5A);
        end

        // Outputs hold in IDLE after done.
        applyStimulus(8'hE7, 4, 2'b10, 1'b0);
        checkOutput(1'b0);
        @(negedge clk);
        checkValue("idle_done", 32'(done), 32'h0);
        checkValue("idle_busy", 32'(busy), 32'h0);
        checkValue("idle_hold_result", 32'(result), 32'(last_res));
        checkValue("idle_hold_cout", 32'(cout), 32'(last_cout));

        // Start pulses and operand changes during SHIFT are ignored.
        applyStimulus(8'b0110_1101, 5, 2'b11, 1'b0);
        checkOutput(1'b1);
        @(negedge clk);
        checkValue("ignored_start_busy", 32'(busy), 32'h0);
        checkValue("ignored_start_done", 32'(done), 32'h0);

        // Start held high: next operation begins on the first IDLE cycle.
        applyStimulus(8'h3C, 3, 2'b00, 1'b1);
        exp_q.push_back(model(8'h3C, 3, 2'b00));
        checkOutput(1'b0);
        @(negedge clk);
        checkValue("b2b_idle_busy", 32'(busy), 32'h0);
        checkValue("b2b_idle_done", 32'(done), 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput(1'b0);

        // Reset in the middle of a run aborts it without a done pulse.
        applyStimulus(8'hC3, 6, 2'b01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkValue("abort_result", 32'(result), 32'h0);
        checkValue("abort_cout", 32'(cout), 32'h0);
        checkValue("abort_busy", 32'(busy), 32'h0);
        checkValue("abort_done", 32'(done), 32'h0);
        exp_q.delete(0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkValue("abort_no_done", 32'(done), 32'h0);
        end
        applyStimulus(8'hC3, 6, 2'b01, 1'b0);
        checkOutput(1'b0);

        // Full sweep against the model.
        for (int d = 0; d < 256; d++) begin
            for (int n = 0; n < W; n++) begin
                for (int o = 0; o < 4; o++) begin
                    err_before = errors;
                    applyStimulus(8'(d), n, 2'(o), 1'b0);
                    checkOutput(1'b0);
                    if (errors != err_before) num_wrong++;
                    else num_correct++;
                end
            end
        end
        $display("[TB] sweep num_correct=%0d num_wrong=%0d", num_correct, num_wrong);
        checkValue("sweep_num_wrong", 32'(num_wrong), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width; power of two, >= 4.
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have port: data_in  input  WIDTH  operand, captured on accepted start.
REQ-006 SHALL have port: shamt  input  log2(WIDTH)  shift amount, captured on accepted start.
REQ-007 SHALL have port: op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR; captured on accepted start.
REQ-008 SHALL have port: result  output  WIDTH  shifted value, registered.
REQ-009 SHALL have port: cout  output  1  last bit shifted out (ROR: last bit rotated to MSB), registered.
REQ-010 SHALL have port: busy  output  1  high in SHIFT state.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; result/cout valid.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE, fully registered; all outputs driven from flops.
REQ-013 IDLE with start=1 at edge k: SHALL load working register = data_in, counter = shamt, op latched, cout cleared; next state SHIFT if shamt != 0, else DONE.
REQ-014 SHIFT: SHALL perform exactly one 1-bit step per clock per latched op and decrement the counter; leave SHIFT for DONE on the edge where the counter reaches 0.
REQ-015 Step rules: SLL shifts in 0 at LSB, cout = old MSB; SRL shifts in 0 at MSB, cout = old LSB; SRA replicates old MSB, cout = old LSB; ROR moves old LSB to MSB, cout = old LSB.
REQ-016 Latency: done SHALL be high exactly in cycle k+N+1 for shamt=N (N=0 gives done in cycle k+1); busy high for exactly N cycles, k+1..k+N.
REQ-017 DONE SHALL last one cycle, then unconditionally return to IDLE; start during DONE SHALL be ignored.
REQ-018 start during SHIFT or DONE SHALL be ignored; data_in/shamt/op changes after capture SHALL NOT affect the operation.
REQ-019 result SHALL equal the working register at all times; result and cout SHALL hold their final values in IDLE until the next accepted start.
REQ-020 shamt=0: result = data_in, cout = 0, for every op.
REQ-021 Maximum shamt (WIDTH-1) SHALL complete normally; counter SHALL never wrap.
REQ-022 start held high continuously SHALL start a new operation on the first IDLE cycle after each DONE (back-to-back period N+2).
REQ-023 done and busy SHALL never be high in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force state IDLE, result = 0, cout = 0, busy = 0, done = 0, counter = 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; first start after rst_n release SHALL behave as from power-up.
REQ-026 Deassertion of rst_n SHALL be treated as synchronous to clk by the environment; the block SHALL NOT accept a start on the edge coincident with deassertion.

Verification
REQ-027 SLL: data_in=8'b1011_0001, shamt=3, op=00 -> busy 3 cycles, done at k+4, result=8'b1000_1000, cout=1.
REQ-028 SRA: data_in=8'b1001_0110, shamt=2, op=10 -> result=8'b1110_0101, cout=1; SRL same inputs op=01 -> result=8'b0010_0101, cout=1.
REQ-029 ROR: data_in=8'h81, shamt=7, op=11 -> done at k+8, result=8'h03, cout=0; shamt=0 any op -> done at k+1, result=data_in, cout=0.
REQ-030 start pulsed at k+1 and k+2 during a shamt=5 run, with data_in changed -> ignored, single done at k+6, result from originally captured operand.
REQ-031 rst_n pulled low at k+2 of a shamt=6 run -> outputs 0 at once, no done; new start after release yields correct result.
REQ-032 Exhaustive self-checking sweep over all data_in, shamt, op (WIDTH=8) against a reference model, counting num_correct/num_wrong; bench SHALL report num_wrong = 0.
